// File: rtl/sram_stream_reader.sv
// Burst read engine for a registered-read SRAM: issues one read per cycle, hides the 1-cycle
// read latency and delivers words on a valid/ready stream through a 2-entry skid buffer.
module sram_stream_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic              busy,
  output logic              mem_cs,
  output logic              mem_web,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              inflight_q;
  logic [1:0]        occ_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic              done_q;

  logic pop;
  logic issue;
  logic drain_done;

  always_comb begin
    pop   = out_valid && out_ready;
    // Buffered plus in-flight words may never exceed the two buffer slots.
    issue = (state_q == StRun) && (remaining_q != '0) &&
            (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    // Leave DRAIN on the edge that empties the buffer, so done lines up with the first IDLE cycle.
    drain_done = (state_q == StDrain) && !inflight_q && (occ_q == {1'b0, pop});
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign done      = done_q;
  assign mem_re    = issue;
  assign mem_cs    = issue;
  assign mem_web   = 1'b1;
  assign mem_raddr = rd_addr_q;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      occ_q      <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      // mem_dout is only meaningful the cycle after a read.
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= mem_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              rd_addr_q   <= cmd_addr;
              remaining_q <= cmd_len;
              state_q     <= StRun;
            end
          end
        end
        StRun: begin
          if (issue) begin
            rd_addr_q   <= rd_addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (drain_done) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed and randomized bursts against a behavioural SRAM and an arithmetic model of the
// expected address/word sequence, issue window and cycle timing.
module tb_sram_stream_reader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned LEN_W  = 11;

  logic              CK = 1'b0;
  logic              RST_N = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              done;
  logic              busy;
  logic              mem_cs;
  logic              mem_web;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_dout;

  logic [DATA_W-1:0] sram [1024];

  int tests = 0;
  int fails = 0;

  sram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .CK        (CK),
    .RST_N     (RST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done),
    .busy      (busy),
    .mem_cs    (mem_cs),
    .mem_web   (mem_web),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout)
  );

  always #5 CK = ~CK;

  // Registered read port: data only the cycle after RE, X otherwise.
  always @(posedge CK) begin
    if (mem_re) mem_dout <= sram[mem_raddr];
    else        mem_dout <= 'x;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_out"}, {out_valid, out_data}, 0);
    check({tag, "_done_busy"}, {done, busy}, 0);
    check({tag, "_sram_pins"}, {mem_cs, mem_re, mem_web, mem_raddr}, {3'b001, 10'h000});
  endtask

  // mode 0: out_ready always 1 (timing checked); 1: 5 low then alternating; 2: random.
  task automatic run_burst(input int addr, input int len, input int mode, input int abort_pops);
    int   issued = 0;
    int   popped = 0;
    int   e = 0;
    int   budget;
    bit   finished = 0;
    bit   saw_done = 0;
    bit   prev_stall = 0;
    bit   pop_now;
    logic rdy;
    logic [DATA_W-1:0] prev_data = '0;
    budget = 20 * len + 50;
    @(negedge CK);
    check("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = LEN_W'(len);
    @(posedge CK);
    @(negedge CK);
    cmd_valid = 1'b0;
    while (!finished) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (e < 5) ? 1'b0 : (((e - 5) % 2) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      #1;
      pop_now = out_valid && rdy;
      check("sram_pins", {mem_cs, mem_web}, {mem_re, 1'b1});
      if (mem_re) begin
        check("raddr", mem_raddr, (addr + issued) % 1024);
        check("issue_window", ((issued - popped - int'(pop_now)) < 2), 1);
        if (mode == 0) check("issue_time", e, issued);
        issued++;
      end
      if (prev_stall) check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
      if (pop_now) begin
        check("data", out_data, 32'h100000 + ((addr + popped) % 1024));
        if (mode == 0) check("pop_time", e, popped + 2);
        popped++;
      end
      prev_stall = out_valid && !rdy;
      prev_data  = out_data;
      if (len == 0 || done) check("busy_ready", {busy, cmd_ready}, 2'b01);
      else                  check("busy_ready", {busy, cmd_ready}, 2'b10);
      if (done) begin
        check("done_words", popped, len);
        check("done_reads", issued, len);
        if (mode == 0) check("done_time", e, (len == 0) ? 0 : len + 2);
        finished = 1;
        saw_done = 1;
      end
      if (abort_pops > 0 && popped == abort_pops) finished = 1;
      e++;
      if (!finished && e > budget) begin
        check("timeout", 0, 1);
        finished = 1;
      end
      @(negedge CK);
    end
    if (saw_done) begin
      #1;
      check("done_single_pulse", done, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = DATA_W'(32'h100000 + i);
    repeat (2) @(negedge CK);
    #1;
    check_reset_values("reset");
    RST_N = 1'b1;

    run_burst(32'h010, 4, 0, 0);
    run_burst(32'h010, 4, 1, 0);
    run_burst(32'h3FE, 4, 0, 0);
    run_burst(32'h3FE, 4, 2, 0);
    run_burst(32'h123, 0, 0, 0);
    run_burst(32'h005, 1, 0, 0);

    // Reset in the middle of a burst, then verify no stale words leak into the next one.
    run_burst(32'h000, 8, 0, 2);
    RST_N = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge CK);
    #1;
    check_reset_values("mid_reset_hold");
    RST_N = 1'b1;
    run_burst(32'h020, 2, 0, 0);

    run_burst(32'h000, 1024, 0, 0);

    for (int i = 0; i < 25; i++) begin
      run_burst(int'($urandom_range(0, 1023)), int'($urandom_range(0, 24)), 2, 0);
    end
    run_burst(int'($urandom_range(0, 1023)), 1030, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
